// File: rtl/deck_access_ctrl_pkg.sv
// Shared constants and types for the deck access controller: deck geometry,
// sentinel codes, FSM state encoding and requester identifiers.
package deck_access_ctrl_pkg;

    localparam int ADDR_W    = 6;
    localparam int CARD_W    = 6;
    localparam int DECK_SIZE = 52;

    localparam logic [ADDR_W-1:0] PARK_ADDR  = 6'h3F;
    localparam logic [CARD_W-1:0] EMPTY_CARD = 6'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_READ,
        ST_WAIT,
        ST_DELIVER
    } state_e;

    typedef enum logic {
        REQ_P = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

endpackage

// File: rtl/deck_access_ctrl_if.sv
// Draw handshake for player/dealer plus the deck RAM port, bundled so the
// controller, the game side and the RAM share one connection.
interface deck_access_ctrl_if;
    import deck_access_ctrl_pkg::*;

    logic              p_req;
    logic              d_req;
    logic              p_valid;
    logic              d_valid;
    logic [CARD_W-1:0] p_card;
    logic [CARD_W-1:0] d_card;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [CARD_W-1:0] ram_wdata;
    logic [CARD_W-1:0] ram_rdata;

    modport master (
        output p_req, d_req, ram_rdata,
        input  p_valid, d_valid, p_card, d_card, ram_addr, ram_wren, ram_wdata
    );

    modport slave (
        input  p_req, d_req, ram_rdata,
        output p_valid, d_valid, p_card, d_card, ram_addr, ram_wren, ram_wdata
    );

endinterface

// File: rtl/deck_access_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the requester that was not
// granted last wins; the last-grant register updates only when update is high.
module rr_arb2
    import deck_access_ctrl_pkg::*;
(
    input  logic    Clock,
    input  logic    resetn,
    input  logic    req_p,
    input  logic    req_d,
    input  logic    update,
    output logic    gnt_any,
    output req_id_e gnt_id
);

    req_id_e last_q;
    req_id_e last_d;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_any = req_p | req_d;
        gnt_id  = REQ_P;
        last_d  = last_q;
        if (req_p && req_d) begin
            gnt_id = (last_q == REQ_D) ? REQ_P : REQ_D;
        end else if (req_d) begin
            gnt_id = REQ_D;
        end
        if (update && gnt_any) begin
            last_d = gnt_id;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample their inputs from the same clock edge.
    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            last_q <= REQ_D;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/deck_access_ctrl.sv
// Sole owner of the deck RAM port: fills the deck on init, serves player and
// dealer draws through a round-robin arbiter, tracks pointer and cards left.
module deck_access_ctrl
    import deck_access_ctrl_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                Clock,
    input  logic                resetn,
    input  logic                init_req,
    deck_access_ctrl_if.slave   bus,
    output logic [5:0]          cards_left,
    output logic                deck_empty,
    output logic                busy
);

    state_e            state_q,      state_d;
    logic [ADDR_W-1:0] fill_idx_q,   fill_idx_d;
    logic [ADDR_W-1:0] ptr_q,        ptr_d;
    logic [5:0]        cards_left_q, cards_left_d;
    req_id_e           winner_q,     winner_d;
    logic [1:0]        wait_cnt_q,   wait_cnt_d;
    logic [CARD_W-1:0] p_card_q,     p_card_d;
    logic [CARD_W-1:0] d_card_q,     d_card_d;

    logic    arb_update;
    logic    arb_gnt_any;
    req_id_e arb_gnt_id;

    rr_arb2 u_arb (
        .Clock   (Clock),
        .resetn  (resetn),
        .req_p   (bus.p_req),
        .req_d   (bus.d_req),
        .update  (arb_update),
        .gnt_any (arb_gnt_any),
        .gnt_id  (arb_gnt_id)
    );

    always_comb begin
        state_d       = state_q;
        fill_idx_d    = fill_idx_q;
        ptr_d         = ptr_q;
        cards_left_d  = cards_left_q;
        winner_d      = winner_q;
        wait_cnt_d    = wait_cnt_q;
        p_card_d      = p_card_q;
        d_card_d      = d_card_q;
        arb_update    = 1'b0;
        bus.ram_addr  = PARK_ADDR;
        bus.ram_wren  = 1'b0;
        bus.ram_wdata = '0;
        bus.p_valid   = 1'b0;
        bus.d_valid   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A fill outranks pending draws; the losers simply stay pending.
                if (init_req) begin
                    fill_idx_d = '0;
                    state_d    = ST_FILL;
                end else if (arb_gnt_any) begin
                    winner_d   = arb_gnt_id;
                    arb_update = 1'b1;
                    state_d    = ST_READ;
                end
            end
            ST_FILL: begin
                bus.ram_addr  = fill_idx_q;
                bus.ram_wdata = fill_idx_q;
                bus.ram_wren  = 1'b1;
                fill_idx_d    = fill_idx_q + 6'd1;
                if (fill_idx_q == 6'(DECK_SIZE - 1)) begin
                    ptr_d        = '0;
                    cards_left_d = 6'(DECK_SIZE);
                    state_d      = ST_IDLE;
                end
            end
            ST_READ: begin
                if (cards_left_q == '0) begin
                    if (winner_q == REQ_P) p_card_d = EMPTY_CARD;
                    else                   d_card_d = EMPTY_CARD;
                    state_d = ST_DELIVER;
                end else begin
                    bus.ram_addr = ptr_q;
                    wait_cnt_d   = '0;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                bus.ram_addr = ptr_q;
                if (wait_cnt_q == 2'(RD_LAT - 1)) begin
                    if (winner_q == REQ_P) p_card_d = bus.ram_rdata;
                    else                   d_card_d = bus.ram_rdata;
                    state_d = ST_DELIVER;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            ST_DELIVER: begin
                bus.p_valid = (winner_q == REQ_P);
                bus.d_valid = (winner_q == REQ_D);
                // cards_left is unchanged since READ, so zero here means the sentinel was sent.
                if (cards_left_q != '0) begin
                    ptr_d        = ptr_q + 6'd1;
                    cards_left_d = cards_left_q - 6'd1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            fill_idx_q   <= '0;
            ptr_q        <= '0;
            cards_left_q <= '0;
            winner_q     <= REQ_P;
            wait_cnt_q   <= '0;
            p_card_q     <= '0;
            d_card_q     <= '0;
        end else begin
            state_q      <= state_d;
            fill_idx_q   <= fill_idx_d;
            ptr_q        <= ptr_d;
            cards_left_q <= cards_left_d;
            winner_q     <= winner_d;
            wait_cnt_q   <= wait_cnt_d;
            p_card_q     <= p_card_d;
            d_card_q     <= d_card_d;
        end
    end

    assign bus.p_card = p_card_q;
    assign bus.d_card = d_card_q;
    assign cards_left = cards_left_q;
    assign deck_empty = (cards_left_q == '0);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_deck_access_ctrl.sv
// Directed bench for deck_access_ctrl: one instance at RD_LAT=1 for the main
// sequence and one at RD_LAT=3 for the fill-then-draw WAIT timing.
module tb_deck_access_ctrl;
    import deck_access_ctrl_pkg::*;

    logic Clock = 1'b0;
    logic resetn = 1'b0;
    logic a_init_req = 1'b0;
    logic b_init_req = 1'b0;
    logic [5:0] a_cards_left, b_cards_left;
    logic a_deck_empty, b_deck_empty, a_busy, b_busy;

    int n_checks = 0;
    int n_errors = 0;

    deck_access_ctrl_if a_if ();
    deck_access_ctrl_if b_if ();

    deck_access_ctrl #(.RD_LAT(1)) dut_a (
        .Clock      (Clock),
        .resetn     (resetn),
        .init_req   (a_init_req),
        .bus        (a_if.slave),
        .cards_left (a_cards_left),
        .deck_empty (a_deck_empty),
        .busy       (a_busy)
    );

    deck_access_ctrl #(.RD_LAT(3)) dut_b (
        .Clock      (Clock),
        .resetn     (resetn),
        .init_req   (b_init_req),
        .bus        (b_if.slave),
        .cards_left (b_cards_left),
        .deck_empty (b_deck_empty),
        .busy       (b_busy)
    );

    always #5 Clock = ~Clock;

    // RAM models: A has one registered read stage, B has three.
    logic [5:0] mem_a [64];
    logic [5:0] mem_b [64];
    logic [5:0] b_p0, b_p1;
    logic       poke_en = 1'b0;
    logic [5:0] poke_addr = '0;
    logic [5:0] poke_data = '0;

    always_ff @(posedge Clock) begin
        if (a_if.ram_wren) mem_a[a_if.ram_addr] <= a_if.ram_wdata;
        else if (poke_en)  mem_a[poke_addr]     <= poke_data;
        a_if.ram_rdata <= mem_a[a_if.ram_addr];
    end

    always_ff @(posedge Clock) begin
        if (b_if.ram_wren) mem_b[b_if.ram_addr] <= b_if.ram_wdata;
        b_p0           <= mem_b[b_if.ram_addr];
        b_p1           <= b_p0;
        b_if.ram_rdata <= b_p1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(negedge Clock);
        resetn = 1'b1;
        @(negedge Clock);
    endtask

    // Starts at an IDLE negedge, ends at the first IDLE negedge after the fill.
    task automatic do_fill_a(input string tag);
        int bad;
        bad = 0;
        a_init_req = 1'b1;
        for (int i = 0; i < DECK_SIZE; i++) begin
            @(negedge Clock);
            if (i == 0) a_init_req = 1'b0;
            if (!(a_if.ram_wren === 1'b1 && a_if.ram_addr == 6'(i) && a_if.ram_wdata == 6'(i)))
                bad++;
        end
        @(negedge Clock);
        check({tag, "_bad_writes"}, bad, 0);
        check({tag, "_wren_off"}, a_if.ram_wren, 0);
        check({tag, "_park"}, a_if.ram_addr, 6'h3F);
        check({tag, "_cards_left"}, a_cards_left, 52);
        check({tag, "_not_empty"}, a_deck_empty, 0);
    endtask

    task automatic wait_valid_a(input req_id_e who, output int lat, output int wr_cnt,
                                output int addr_cnt, output int other_cnt);
        lat = 0; wr_cnt = 0; addr_cnt = 0; other_cnt = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge Clock);
            if (a_if.ram_wren) wr_cnt++;
            if (a_if.ram_addr != PARK_ADDR) addr_cnt++;
            if (who == REQ_P ? a_if.d_valid : a_if.p_valid) other_cnt++;
            if (who == REQ_P ? a_if.p_valid : a_if.d_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    // One draw from an IDLE negedge; ends at the following IDLE negedge.
    task automatic draw_a(input req_id_e who, input logic [5:0] exp_card, input int exp_lat,
                          input string tag, output int addr_cnt);
        int lat, wr, oth;
        logic [5:0] card;
        if (who == REQ_P) a_if.p_req = 1'b1;
        else              a_if.d_req = 1'b1;
        wait_valid_a(who, lat, wr, addr_cnt, oth);
        a_if.p_req = 1'b0;
        a_if.d_req = 1'b0;
        card = (who == REQ_P) ? a_if.p_card : a_if.d_card;
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_card"}, card, exp_card);
        check({tag, "_other_valid"}, oth, 0);
        @(negedge Clock);
        check({tag, "_valid_pulse"}, {a_if.p_valid, a_if.d_valid}, 0);
    endtask

    initial begin
        int ac, lat, wr, oth, first_wr, n_valid, bad, addr0_cnt;
        req_id_e who_q[$];
        logic [5:0] card_q[$];
        int p_taken, d_taken;

        a_if.p_req = 1'b0; a_if.d_req = 1'b0;
        b_if.p_req = 1'b0; b_if.d_req = 1'b0;

        // Reset values, checked while reset is still asserted and after release.
        @(negedge Clock);
        check("rst_cards_left", a_cards_left, 0);
        check("rst_deck_empty", a_deck_empty, 1);
        check("rst_busy", a_busy, 0);
        check("rst_ram_addr", a_if.ram_addr, 6'h3F);
        check("rst_ram_wren", a_if.ram_wren, 0);
        check("rst_ram_wdata", a_if.ram_wdata, 0);
        check("rst_valids", {a_if.p_valid, a_if.d_valid}, 0);
        check("rst_cards", {a_if.p_card, a_if.d_card}, 0);
        do_reset();
        check("rst_rel_park", a_if.ram_addr, 6'h3F);

        // Deck fill.
        do_fill_a("t1");

        // Both requesting, each re-raising after its own delivery: strict alternation.
        a_if.p_req = 1'b1; a_if.d_req = 1'b1;
        p_taken = 0; d_taken = 0;
        for (int i = 0; i < 100 && who_q.size() < 4; i++) begin
            @(negedge Clock);
            if (a_if.p_valid) begin
                who_q.push_back(REQ_P); card_q.push_back(a_if.p_card);
                p_taken++; a_if.p_req = 1'b0;
            end else if (!a_if.p_req && p_taken < 2) a_if.p_req = 1'b1;
            if (a_if.d_valid) begin
                who_q.push_back(REQ_D); card_q.push_back(a_if.d_card);
                d_taken++; a_if.d_req = 1'b0;
            end else if (!a_if.d_req && d_taken < 2) a_if.d_req = 1'b1;
        end
        a_if.p_req = 1'b0; a_if.d_req = 1'b0;
        @(negedge Clock);
        check("t3_grants", who_q.size(), 4);
        for (int i = 0; i < 4 && i < who_q.size(); i++) begin
            check($sformatf("t3_who%0d", i), who_q[i], (i % 2 == 0) ? REQ_P : REQ_D);
            check($sformatf("t3_card%0d", i), card_q[i], i);
        end
        check("t3_cards_left", a_cards_left, 48);

        // Single player draw from a fresh deck with addr 0 overwritten to 17.
        do_reset();
        do_fill_a("t2fill");
        poke_en = 1'b1; poke_addr = 6'd0; poke_data = 6'd17;
        @(negedge Clock);
        poke_en = 1'b0;
        draw_a(REQ_P, 6'd17, 3, "t2", ac);
        check("t2_cards_left", a_cards_left, 51);
        check("t2_d_card_held", a_if.d_card, 0);

        // Drain the deck, then one draw past empty.
        bad = 0;
        for (int i = 1; i < DECK_SIZE; i++) begin
            draw_a(REQ_P, 6'(i), 3, $sformatf("t4_draw%0d", i), ac);
        end
        check("t4_cards_left_0", a_cards_left, 0);
        check("t4_deck_empty", a_deck_empty, 1);
        check("t4_p_card_last", a_if.p_card, 51);
        draw_a(REQ_D, 6'h3F, 2, "t4_empty", ac);
        check("t4_empty_no_read", ac, 0);
        check("t4_empty_cards_left", a_cards_left, 0);
        check("t4_p_card_held", a_if.p_card, 51);

        // Reset during WAIT aborts the draw.
        do_fill_a("t5fill");
        a_if.p_req = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        check("t5_in_wait_addr", a_if.ram_addr, 0);
        check("t5_in_wait_busy", a_busy, 1);
        resetn = 1'b0;
        #1;
        check("t5_rst_busy", a_busy, 0);
        check("t5_rst_park", a_if.ram_addr, 6'h3F);
        a_if.p_req = 1'b0;
        repeat (2) @(negedge Clock);
        resetn = 1'b1;
        n_valid = 0;
        repeat (6) begin
            @(negedge Clock);
            if (a_if.p_valid || a_if.d_valid) n_valid++;
        end
        check("t5_no_valid", n_valid, 0);
        check("t5_cards_left", a_cards_left, 0);
        check("t5_park", a_if.ram_addr, 6'h3F);
        check("t5_p_card", a_if.p_card, 0);
        do_fill_a("t5_refill");

        // init_req and p_req together: fill first, then the draw returns addr 0.
        a_init_req = 1'b1; a_if.p_req = 1'b1;
        @(negedge Clock);
        a_init_req = 1'b0;
        first_wr = a_if.ram_wren ? 1 : 0;
        wait_valid_a(REQ_P, lat, wr, ac, oth);
        a_if.p_req = 1'b0;
        check("t6a_lat", (lat == 0) ? 0 : lat + 1, 56);
        check("t6a_writes", first_wr + wr, 52);
        check("t6a_card", a_if.p_card, 0);
        @(negedge Clock);
        check("t6a_cards_left", a_cards_left, 51);

        // Same on the RD_LAT=3 instance; addr 0 held without write for READ + 3 WAIT cycles.
        b_init_req = 1'b1; b_if.p_req = 1'b1;
        lat = 0; wr = 0; addr0_cnt = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge Clock);
            if (i == 1) b_init_req = 1'b0;
            if (b_if.ram_wren) wr++;
            if (!b_if.ram_wren && b_if.ram_addr == 6'd0) addr0_cnt++;
            if (b_if.p_valid) begin
                lat = i;
                break;
            end
        end
        b_if.p_req = 1'b0;
        check("t6b_lat", lat, 58);
        check("t6b_writes", wr, 52);
        check("t6b_addr_hold", addr0_cnt, 4);
        check("t6b_card", b_if.p_card, 0);
        @(negedge Clock);
        check("t6b_cards_left", b_cards_left, 51);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
